lfsr_prng_sched: RTL and testbench
==================================

# lfsr_prng_sched

Controller and round-robin scheduler for the two-layer LFSR pseudo-random generator: a 16-bit upper LFSR and an 8-bit lower LFSR, combined as upper[7:0] XOR lower. It sequences the generator through seed load and warm-up, then shares the combined 8-bit random word among NREQ requesters. Each grant consumes one word and advances both LFSRs. It sits between the LFSR pair and the blocks that need random stimulus.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8.
- WARMUP, 16: LFSR steps discarded after every seed load, 1..255.
- SEED_UP_RST, 16'h0005: upper seed loaded after reset.
- SEED_DN_RST, 8'h0E: lower seed loaded after reset.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- reseed  in  1  pulse; when sampled high, latch seed_up_in and seed_dn_in and restart the seed sequence.
- seed_up_in  in  16  new upper seed.
- seed_dn_in  in  8  new lower seed.
- lfsr_up_q  in  16  upper LFSR state.
- lfsr_dn_q  in  8  lower LFSR state.
- lfsr_load  out  1  load seeds into both LFSRs this cycle.
- lfsr_step  out  1  advance both LFSRs this cycle.
- lfsr_up_seed  out  16  upper seed value; valid while lfsr_load is high.
- lfsr_dn_seed  out  8  lower seed value; valid while lfsr_load is high.
- req  in  NREQ  per-requester request level.
- gnt  out  NREQ  one-hot grant pulse, registered.
- rnd_data  out  8  random word delivered with gnt, registered.
- rnd_valid  out  1  equals OR of gnt.
- ready  out  1  high only in SERVE.
- served_cnt  out  16  words delivered since the last seed load; wraps.

## Operation
- State machine: IDLE → LOAD → WARM → SERVE.
- **IDLE**
  - Entered on reset.
  - Moves to LOAD on the next cycle.
- **LOAD**
  - Exactly one cycle with lfsr_load=1.
  - Seeds are the latched reseed values, or SEED_*_RST if no reseed has occurred since reset.
  - Then moves to WARM.
- **WARM**
  - lfsr_step=1 every cycle for WARMUP cycles, counted by an 8-bit counter.
  - Then moves to SERVE.
  - No grants are issued in WARM.
- **SERVE**
  - In any cycle where req≠0, pick a requester round-robin.
  - Search starts at the index after the last granted one; after a seed load it starts at index 0.
  - Next cycle: gnt[k]=1, rnd_data = lfsr_up_q[7:0] ^ lfsr_dn_q as sampled at the decision, served_cnt += 1.
  - lfsr_step=1 in the decision cycle, so consecutive words come from consecutive LFSR states.
  - With no request, lfsr_step=0 and gnt=0.
- Requesters hold req until granted. A requester that keeps req high is served again at its next round-robin turn.
- **Reseed**
  - reseed sampled high in any state other than IDLE: latch seeds, go to LOAD, clear served_cnt.
  - In SERVE, a grant decided in the same cycle is suppressed: no gnt the next cycle.
  - reseed during LOAD or WARM restarts the sequence from LOAD.
- All-zero seeds are legal inputs. See Configuration for lockup handling.

## Timing
- Reset values:
  - gnt=0, rnd_valid=0, rnd_data=0.
  - lfsr_load=0, lfsr_step=0.
  - ready=0, served_cnt=0, rr pointer=0.
  - Latched seeds = SEED_*_RST.
- From rst_n rising:
  - lfsr_load is high on cycle 1.
  - WARM covers cycles 2..WARMUP+1.
  - ready is high from cycle WARMUP+2.
- Grant latency is 1 cycle from req sampled in SERVE.
- Throughput: at most 1 grant per cycle.
- rst_n low mid-operation returns to IDLE on the next edge and drops any pending grant.
- served_cnt wraps from 16'hFFFF to 0.

## Configuration
- PRNG_LOCKUP_DETECT_EN defined:
  - In SERVE, if lfsr_up_q==0 or lfsr_dn_q==0, no grant is issued that cycle.
  - Latched seeds are set to SEED_*_RST and the block goes to LOAD.
  - A sticky output lockup_seen (1 bit, reset 0) is set.
  - Any requested seed equal to 0 is replaced by SEED_*_RST at LOAD.
- Not defined: no zero checks; the lockup_seen port does not exist.

## Test plan
- Reset → cycle 1: lfsr_load=1 with seeds 16'h0005 / 8'h0E. ready rises at cycle 18 (WARMUP=16). No gnt before cycle 18.
- req=4'b1111 held in SERVE → gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles. Each rnd_data equals the model's upper[7:0]^lower. served_cnt increments 1..5.
- req=4'b0100 only, held 3 cycles → gnt=0100 three times. rr pointer then starts the search at index 3: with req=4'b1001, index 3 is granted first.
- Reseed with 16'h00FF / 8'h0F during continuous grants → no gnt the cycle after reseed. lfsr_load shows the new seeds. served_cnt=0. ready returns after WARMUP cycles.
- Force served_cnt to 16'hFFFF, then one grant → served_cnt=0.
- With PRNG_LOCKUP_DETECT_EN, reseed with seed_dn_in=0 → LOAD outputs lfsr_dn_seed=8'h0E and lockup_seen=1. Without the macro, lfsr_dn_seed=8'h00.

Source files
------------

// File: rtl/lfsr_prng_sched.sv
// Purpose     : seed/warm-up sequencer for an external 16b+8b LFSR pair; shares word upper[7:0]^lower round-robin.
// Latency     : gnt/rnd_data registered, one cycle after the request is sampled in SERVE.
// Backpressure: requesters hold req until granted; at most one grant (one LFSR step) per cycle.
// Ports: clk, rst_n (synchronous, active-low); reseed + seed_up_in/seed_dn_in restart the seed sequence;
//   lfsr_up_q/lfsr_dn_q observe the LFSR pair, lfsr_load/lfsr_step/lfsr_up_seed/lfsr_dn_seed drive it;
//   req -> gnt/rnd_data/rnd_valid; ready (serving), served_cnt (words since last seed load, wraps).
// Option: define PRNG_LOCKUP_DETECT_EN to add zero-state/zero-seed recovery and the sticky lockup_seen output.
module lfsr_prng_sched #(
   parameter int unsigned NREQ        = 4,
   parameter int unsigned WARMUP      = 16,
   parameter logic [15:0] SEED_UP_RST = 16'h0005,
   parameter logic [7:0]  SEED_DN_RST = 8'h0E
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            reseed,
   input  logic [15:0]     seed_up_in,
   input  logic [7:0]      seed_dn_in,
   input  logic [15:0]     lfsr_up_q,
   input  logic [7:0]      lfsr_dn_q,
   output logic            lfsr_load,
   output logic            lfsr_step,
   output logic [15:0]     lfsr_up_seed,
   output logic [7:0]      lfsr_dn_seed,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic [7:0]      rnd_data,
   output logic            rnd_valid,
   output logic            ready,
   output logic [15:0]     served_cnt
`ifdef PRNG_LOCKUP_DETECT_EN
   ,
   output logic            lockup_seen
`endif
);

   localparam int unsigned PW        = $clog2(NREQ);
   localparam logic [7:0]  WARM_LAST = 8'(WARMUP - 1);

   typedef enum logic [1:0] {IDLE, LOAD, WARM, SERVE} state_t;

   state_t          state_q, state_d;
   logic [7:0]      warm_cnt;
   logic [PW-1:0]   ptr;        // first index searched at the next decision
   logic [15:0]     seed_up;
   logic [7:0]      seed_dn;

   logic            restart;    // reseed honoured this cycle
   logic            lock_hit;
   logic            grant_go;
   logic            hi_vld;
   logic [PW-1:0]   hi_idx, lo_idx, pick, ptr_nx;
   logic [NREQ-1:0] pick_oh;

   assign restart = reseed && (state_q != IDLE);

`ifdef PRNG_LOCKUP_DETECT_EN
   assign lock_hit = (state_q == SERVE) && ((lfsr_up_q == 16'h0000) || (lfsr_dn_q == 8'h00));
`else
   assign lock_hit = 1'b0;
`endif

   // Round-robin: lowest requester at or above ptr wins; otherwise wrap to the
   // lowest requester overall. Descending scan leaves the lowest match last.
   always_comb begin
      hi_vld = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_idx = PW'(i);
            if (PW'(i) >= ptr) begin
               hi_vld = 1'b1;
               hi_idx = PW'(i);
            end
         end
      end
      pick    = hi_vld ? hi_idx : lo_idx;
      ptr_nx  = (pick == PW'(NREQ - 1)) ? '0 : pick + PW'(1);
      pick_oh = '0;
      pick_oh[pick] = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      lfsr_step = 1'b0;
      grant_go  = 1'b0;
      case (state_q)
         IDLE: state_d = LOAD;
         LOAD: state_d = WARM;
         WARM: begin
            lfsr_step = 1'b1;
            if (warm_cnt == WARM_LAST) state_d = SERVE;
         end
         SERVE: begin
            if (lock_hit) begin
               state_d = LOAD;
            end else if ((|req) && !reseed) begin
               // A reseed in the same cycle drops the decision entirely, so
               // the LFSRs are not stepped either; they get reloaded anyway.
               grant_go  = 1'b1;
               lfsr_step = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (restart) state_d = LOAD;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         warm_cnt   <= '0;
         ptr        <= '0;
         seed_up    <= SEED_UP_RST;
         seed_dn    <= SEED_DN_RST;
         gnt        <= '0;
         rnd_data   <= '0;
         served_cnt <= '0;
`ifdef PRNG_LOCKUP_DETECT_EN
         lockup_seen <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gnt     <= '0;

         if (state_q == LOAD) begin
            warm_cnt   <= '0;
            ptr        <= '0;
            served_cnt <= '0;
         end else if (state_q == WARM) begin
            warm_cnt <= warm_cnt + 8'd1;
         end

         if (grant_go) begin
            gnt        <= pick_oh;
            rnd_data   <= lfsr_up_q[7:0] ^ lfsr_dn_q;
            served_cnt <= served_cnt + 16'd1;
            ptr        <= ptr_nx;
         end

         if (restart) begin
            served_cnt <= '0;
`ifdef PRNG_LOCKUP_DETECT_EN
            // Zero seeds would park the LFSRs; substitute the reset seeds at
            // latch time so LOAD already presents the safe values.
            seed_up <= (seed_up_in == 16'h0000) ? SEED_UP_RST : seed_up_in;
            seed_dn <= (seed_dn_in == 8'h00) ? SEED_DN_RST : seed_dn_in;
            if ((seed_up_in == 16'h0000) || (seed_dn_in == 8'h00)) lockup_seen <= 1'b1;
`else
            seed_up <= seed_up_in;
            seed_dn <= seed_dn_in;
`endif
         end
`ifdef PRNG_LOCKUP_DETECT_EN
         else if (lock_hit) begin
            seed_up     <= SEED_UP_RST;
            seed_dn     <= SEED_DN_RST;
            lockup_seen <= 1'b1;
         end
`endif
      end
   end

   assign lfsr_load    = (state_q == LOAD);
   assign lfsr_up_seed = seed_up;
   assign lfsr_dn_seed = seed_dn;
   assign rnd_valid    = |gnt;
   assign ready        = (state_q == SERVE);

endmodule

// File: tb/tb_lfsr_prng_sched.sv
// Bench for lfsr_prng_sched: drives an LFSR pair from the DUT's load/step controls
// and checks every cycle against a cycle-count / word-stream reference model,
// plus a vector table and hand sequences for startup, reseed, lockup and wrap.
module tb_lfsr_prng_sched;
   localparam int          NREQ    = 4;
   localparam int          WARMUP  = 16;
   localparam logic [15:0] SUP_RST = 16'h0005;
   localparam logic [7:0]  SDN_RST = 8'h0E;
`ifdef PRNG_LOCKUP_DETECT_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n, reseed;
   logic [15:0]     seed_up_in;
   logic [7:0]      seed_dn_in;
   logic [15:0]     lfsr_up_q = '0;
   logic [7:0]      lfsr_dn_q = '0;
   logic            lfsr_load, lfsr_step;
   logic [15:0]     lfsr_up_seed;
   logic [7:0]      lfsr_dn_seed;
   logic [NREQ-1:0] req, gnt;
   logic [7:0]      rnd_data;
   logic            rnd_valid, ready;
   logic [15:0]     served_cnt;
`ifdef PRNG_LOCKUP_DETECT_EN
   logic            lockup_seen;
`endif

   lfsr_prng_sched #(.NREQ(NREQ), .WARMUP(WARMUP), .SEED_UP_RST(SUP_RST), .SEED_DN_RST(SDN_RST)) dut (
      .clk(clk), .rst_n(rst_n), .reseed(reseed), .seed_up_in(seed_up_in), .seed_dn_in(seed_dn_in),
      .lfsr_up_q(lfsr_up_q), .lfsr_dn_q(lfsr_dn_q), .lfsr_load(lfsr_load), .lfsr_step(lfsr_step),
      .lfsr_up_seed(lfsr_up_seed), .lfsr_dn_seed(lfsr_dn_seed), .req(req), .gnt(gnt),
      .rnd_data(rnd_data), .rnd_valid(rnd_valid), .ready(ready), .served_cnt(served_cnt)
`ifdef PRNG_LOCKUP_DETECT_EN
      , .lockup_seen(lockup_seen)
`endif
   );

   function automatic logic [15:0] up_nx(input logic [15:0] q);
      return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
   endfunction
   function automatic logic [7:0] dn_nx(input logic [7:0] q);
      return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
   endfunction

   // The LFSR pair the controller sits in front of.
   always @(posedge clk) begin
      if (lfsr_load) begin
         lfsr_up_q <= lfsr_up_seed;
         lfsr_dn_q <= lfsr_dn_seed;
      end else if (lfsr_step) begin
         lfsr_up_q <= up_nx(lfsr_up_q);
         lfsr_dn_q <= dn_nx(lfsr_dn_q);
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model. m_t = cycles since the current seed-load cycle began
   // (-1 before the first load); serving once m_t exceeds WARMUP.
   int              m_t = -1;
   int              m_ptr = 0;
   logic [15:0]     m_sup = SUP_RST;
   logic [7:0]      m_sdn = SDN_RST;
   logic [15:0]     m_wu, m_wd16;
   logic [7:0]      m_wd;
   logic [15:0]     m_cnt = '0;
   logic [NREQ-1:0] m_gnt = '0;
   logic [7:0]      m_data = '0;
   bit              m_seen = 1'b0;

   // Next word the pair will hold when serving starts: seed advanced WARMUP times.
   task automatic start_load();
      m_t   = 0;
      m_ptr = 0;
      m_cnt = '0;
      m_wu  = m_sup;
      m_wd  = m_sdn;
      repeat (WARMUP) begin
         m_wu = up_nx(m_wu);
         m_wd = dn_nx(m_wd);
      end
   endtask

   task automatic model_edge();
      int k;
      m_gnt = '0;
      if (!rst_n) begin
         m_t = -1; m_sup = SUP_RST; m_sdn = SDN_RST; m_cnt = '0; m_data = '0; m_seen = 1'b0; m_ptr = 0;
      end else if (m_t < 0) begin
         start_load();
      end else if (reseed) begin
         m_sup = seed_up_in;
         m_sdn = seed_dn_in;
         if (LOCK_EN && (seed_up_in == 16'h0 || seed_dn_in == 8'h0)) begin
            if (seed_up_in == 16'h0) m_sup = SUP_RST;
            if (seed_dn_in == 8'h0)  m_sdn = SDN_RST;
            m_seen = 1'b1;
         end
         start_load();
      end else if (m_t <= WARMUP) begin
         m_t++;
      end else if (LOCK_EN && (m_wu == 16'h0 || m_wd == 8'h0)) begin
         m_sup = SUP_RST; m_sdn = SDN_RST; m_seen = 1'b1;
         start_load();
      end else if (req != '0) begin
         k = -1;
         for (int n = 0; n < NREQ; n++)
            if (k < 0 && req[(m_ptr + n) % NREQ]) k = (m_ptr + n) % NREQ;
         m_gnt[k] = 1'b1;
         m_data   = m_wu[7:0] ^ m_wd;
         m_wu     = up_nx(m_wu);
         m_wd     = dn_nx(m_wd);
         m_cnt    = m_cnt + 16'd1;
         m_ptr    = (k + 1) % NREQ;
      end
   endtask

   function automatic bit exp_step();
      if (m_t >= 1 && m_t <= WARMUP) return 1'b1;
      if (m_t > WARMUP && !reseed && req != '0 && !(LOCK_EN && (m_wu == 16'h0 || m_wd == 8'h0))) return 1'b1;
      return 1'b0;
   endfunction

   // One cycle: check the combinational step for the inputs just driven, take
   // the edge, advance the model, then compare the registered outputs.
   task automatic tick();
      #1;
      if (rst_n) chk("lfsr_step", 32'(lfsr_step), 32'(exp_step()));
      @(posedge clk);
      model_edge();
      #1;
      chk("gnt", 32'(gnt), 32'(m_gnt));
      chk("rnd_valid", 32'(rnd_valid), 32'(|m_gnt));
      chk("rnd_data", 32'(rnd_data), 32'(m_data));
      chk("lfsr_load", 32'(lfsr_load), 32'(m_t == 0));
      chk("ready", 32'(ready), 32'(m_t > WARMUP));
      chk("served_cnt", 32'(served_cnt), 32'(m_cnt));
      if (m_t == 0) begin
         chk("up_seed", 32'(lfsr_up_seed), 32'(m_sup));
         chk("dn_seed", 32'(lfsr_dn_seed), 32'(m_sdn));
      end
`ifdef PRNG_LOCKUP_DETECT_EN
      chk("lockup_seen", 32'(lockup_seen), 32'(m_seen));
`endif
   endtask

   typedef struct {
      logic [NREQ-1:0] req;
      logic [NREQ-1:0] gnt;
      logic [15:0]     cnt;
   } vec_t;
   vec_t tbl [11];

   initial begin
      int first_rdy;
      int n;

      tbl[0]  = '{4'b1111, 4'b0001, 16'd1};
      tbl[1]  = '{4'b1111, 4'b0010, 16'd2};
      tbl[2]  = '{4'b1111, 4'b0100, 16'd3};
      tbl[3]  = '{4'b1111, 4'b1000, 16'd4};
      tbl[4]  = '{4'b1111, 4'b0001, 16'd5};
      tbl[5]  = '{4'b0100, 4'b0100, 16'd6};
      tbl[6]  = '{4'b0100, 4'b0100, 16'd7};
      tbl[7]  = '{4'b0100, 4'b0100, 16'd8};
      tbl[8]  = '{4'b1001, 4'b1000, 16'd9};
      tbl[9]  = '{4'b1001, 4'b0001, 16'd10};
      tbl[10] = '{4'b0000, 4'b0000, 16'd10};

      rst_n = 1'b0; reseed = 1'b0; req = '0; seed_up_in = '0; seed_dn_in = '0;
      repeat (3) tick();
      chk("rst_served_cnt", 32'(served_cnt), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);

      // Startup: requests already pending during warm-up must not be granted.
      rst_n = 1'b1;
      req = 4'b1111;
      first_rdy = -1;
      for (int c = 1; c <= WARMUP + 2; c++) begin
         tick();
         if (c == 1) begin
            chk("load_c1", 32'(lfsr_load), 32'd1);
            chk("load_c1_up", 32'(lfsr_up_seed), 32'h0005);
            chk("load_c1_dn", 32'(lfsr_dn_seed), 32'h0E);
         end
         chk("no_early_gnt", 32'(gnt), 32'd0);
         if (ready && first_rdy < 0) first_rdy = c;
      end
      chk("ready_rise_cycle", 32'(first_rdy), 32'(WARMUP + 2));

      for (int i = 0; i < 11; i++) begin
         req = tbl[i].req;
         tick();
         chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
         chk($sformatf("tbl%0d_cnt", i), 32'(served_cnt), 32'(tbl[i].cnt));
      end

      // Reseed while grants are flowing.
      req = 4'b1111;
      repeat (3) tick();
      reseed = 1'b1; seed_up_in = 16'h00FF; seed_dn_in = 8'h0F;
      tick();
      reseed = 1'b0;
      chk("reseed_no_gnt", 32'(gnt), 32'd0);
      chk("reseed_cnt_clr", 32'(served_cnt), 32'd0);
      chk("reseed_load", 32'(lfsr_load), 32'd1);
      chk("reseed_up_seed", 32'(lfsr_up_seed), 32'h00FF);
      chk("reseed_dn_seed", 32'(lfsr_dn_seed), 32'h0F);
      n = 0;
      while (!ready && n < 100) begin
         tick();
         n++;
      end
      chk("reseed_ready_lat", 32'(n), 32'(WARMUP + 1));
      repeat (4) tick();

      // Reset in the middle of serving drops the pending grant.
      rst_n = 1'b0;
      tick();
      chk("midrst_gnt", 32'(gnt), 32'd0);
      chk("midrst_ready", 32'(ready), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 400; i++) begin
         req        = NREQ'($urandom);
         reseed     = ($urandom_range(0, 39) == 0);
         seed_up_in = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         seed_dn_in = ($urandom_range(0, 3) == 0) ? 8'h0 : 8'($urandom);
         rst_n      = ($urandom_range(0, 149) != 0);
         tick();
      end
      rst_n = 1'b1; reseed = 1'b0; req = '0;
      repeat (2) tick();

      // Zero lower seed.
      reseed = 1'b1; seed_up_in = 16'h1234; seed_dn_in = 8'h00;
      tick();
      reseed = 1'b0;
      chk("zero_seed_load", 32'(lfsr_load), 32'd1);
      chk("zero_seed_dn", 32'(lfsr_dn_seed), LOCK_EN ? 32'h0E : 32'h00);
`ifdef PRNG_LOCKUP_DETECT_EN
      chk("zero_seed_lockup", 32'(lockup_seen), 32'd1);
`endif

      // Counter wrap: grant continuously until 16'hFFFF words, then one more.
      reseed = 1'b1; seed_up_in = 16'hACE1; seed_dn_in = 8'h5A;
      tick();
      reseed = 1'b0;
      req = 4'b1111;
      n = 0;
      while (m_cnt != 16'hFFFF && n < 70000) begin
         tick();
         n++;
      end
      chk("cnt_ffff", 32'(served_cnt), 32'hFFFF);
      tick();
      chk("cnt_wrap", 32'(served_cnt), 32'h0);
      chk("cnt_wrap_gnt", 32'(gnt), 32'(m_gnt));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
